// File: rtl/seq_shift_imm_unit.sv
// seq_shift_imm_unit: multi-cycle shift / rotate / immediate-formation unit.
// A shift moves the work register one bit per clock. LUI is run as a shift
// left by (WIDTH-IMM_W). SEXT/ZEXT and zero-amount shifts finish in one cycle.
// Handshake: an accepted start raises busy. done pulses for one cycle while
// result is loaded.
// Constraints: SHAMT_W == clog2(WIDTH) and IMM_W < WIDTH.
module seq_shift_imm_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int IMM_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [IMM_W-1:0]   imm,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [2:0] MODE_SLL  = 3'b000;
  localparam logic [2:0] MODE_SRL  = 3'b001;
  localparam logic [2:0] MODE_SRA  = 3'b010;
  localparam logic [2:0] MODE_LUI  = 3'b011;
  localparam logic [2:0] MODE_SEXT = 3'b100;
  localparam logic [2:0] MODE_ZEXT = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;
  localparam logic [2:0] MODE_ROR  = 3'b111;

  // LUI places the immediate in the upper bits by shifting it left this far.
  localparam logic [SHAMT_W-1:0] LUI_SHIFT = SHAMT_W'(WIDTH - IMM_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   work_r;
  logic [WIDTH-1:0]   work_next_s;
  logic [SHAMT_W-1:0] count_r;
  logic [SHAMT_W-1:0] count_next_s;
  logic [2:0]         mode_r;
  logic [2:0]         mode_next_s;
  logic [WIDTH-1:0]   result_r;
  logic [WIDTH-1:0]   result_next_s;
  logic               busy_r;
  logic               busy_next_s;
  logic               done_r;
  logic               done_next_s;

  logic               accept_s;
  logic [WIDTH-1:0]   load_work_s;
  logic [SHAMT_W-1:0] load_count_s;

  // Single-bit step of the work register for the latched operation.
  // LUI shifts left. SEXT/ZEXT never reach the shift state.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic [2:0]       m);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_SLL, MODE_LUI: r = {v[WIDTH-2:0], 1'b0};
      MODE_SRL:           r = {1'b0, v[WIDTH-1:1]};
      MODE_SRA:           r = {v[WIDTH-1], v[WIDTH-1:1]};
      MODE_ROL:           r = {v[WIDTH-2:0], v[WIDTH-1]};
      MODE_ROR:           r = {v[0], v[WIDTH-1:1]};
      default:            r = v;
    endcase
    return r;
  endfunction

  assign accept_s = (state_r == ST_IDLE) && start;

  // Decode the starting work value and the step count from the request inputs.
  always_comb begin
    load_work_s  = operand;
    load_count_s = shamt;
    case (mode)
      MODE_LUI: begin
        load_work_s  = {{(WIDTH-IMM_W){1'b0}}, imm};
        load_count_s = LUI_SHIFT;
      end
      MODE_SEXT: begin
        load_work_s  = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
        load_count_s = {SHAMT_W{1'b0}};
      end
      MODE_ZEXT: begin
        load_work_s  = {{(WIDTH-IMM_W){1'b0}}, imm};
        load_count_s = {SHAMT_W{1'b0}};
      end
      default: begin
        load_work_s  = operand;
        load_count_s = shamt;
      end
    endcase
  end

  // State register. Reset drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. A zero step count goes straight to completion.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (load_count_s != {SHAMT_W{1'b0}}) begin
            state_next_s = ST_SHIFT;
          end else begin
            state_next_s = ST_DONE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (count_r == SHAMT_W'(1)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath next values. Inputs are captured only on acceptance.
  // result is loaded only when entering DONE.
  always_comb begin
    work_next_s  = work_r;
    count_next_s = count_r;
    mode_next_s  = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          work_next_s  = load_work_s;
          count_next_s = load_count_s;
          mode_next_s  = mode;
        end else begin
          work_next_s  = work_r;
          count_next_s = count_r;
          mode_next_s  = mode_r;
        end
      end
      ST_SHIFT: begin
        work_next_s  = shift_one(work_r, mode_r);
        count_next_s = count_r - SHAMT_W'(1);
      end
      ST_DONE: begin
        work_next_s  = work_r;
        count_next_s = count_r;
      end
      default: begin
        work_next_s  = work_r;
        count_next_s = count_r;
      end
    endcase
    if (state_next_s == ST_DONE) begin
      result_next_s = work_next_s;
    end else begin
      result_next_s = result_r;
    end
  end

  // Output decode. The values are computed one cycle early and then registered.
  always_comb begin
    busy_next_s = (state_next_s != ST_IDLE);
    done_next_s = (state_next_s == ST_DONE);
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_r   <= {WIDTH{1'b0}};
      count_r  <= {SHAMT_W{1'b0}};
      mode_r   <= 3'b000;
      result_r <= {WIDTH{1'b0}};
    end else begin
      work_r   <= work_next_s;
      count_r  <= count_next_s;
      mode_r   <= mode_next_s;
      result_r <= result_next_s;
    end
  end

  // Output registers. busy and done track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_next_s;
      done_r <= done_next_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_seq_shift_imm_unit.sv
// Directed testbench for seq_shift_imm_unit. The 32-bit configuration is used.
module tb_seq_shift_imm_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  mode;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp;
  int n_err;

  seq_shift_imm_unit #(.WIDTH(32), .SHAMT_W(5), .IMM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .operand(operand),
    .shamt(shamt), .imm(imm), .busy(busy), .done(done), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Run one operation. Inputs are driven at a negedge, and the request is
  // accepted at the following posedge (cycle T). Outputs are then sampled at
  // each negedge, so k=1 is cycle T+1. If inject is set, a spurious start
  // with other values is applied in SHIFT and again in DONE.
  task automatic run_op(input logic [2:0] m, input logic [31:0] op,
                        input logic [4:0] sh, input logic [15:0] im,
                        input logic [31:0] exp_res, input int lat,
                        input bit inject, input string name);
    int k;
    @(negedge clk);
    mode = m; operand = op; shamt = sh; imm = im; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~m; operand = ~op; shamt = ~sh; imm = ~im;
    k = 1;
    while (done !== 1'b1 && k <= 40) begin
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s busy@%0d: got %b want 1", name, k, busy);
      end
      start = (inject && k == 2);
      @(negedge clk);
      k++;
    end
    start = inject;
    n_cmp++;
    if (k != lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, k, lat);
    end
    n_cmp++;
    if (result !== exp_res) begin
      n_err++;
      $display("FAIL %s result: got %h want %h", name, result, exp_res);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_at_done: got %b want 1", name, busy);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s back_to_idle: got done=%b busy=%b want 0 0", name, done, busy);
    end
    n_cmp++;
    if (result !== exp_res) begin
      n_err++;
      $display("FAIL %s result_hold: got %h want %h", name, result, exp_res);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL reset_async: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lui();
    run_op(3'b011, 32'hFFFF_FFFF, 5'd3, 16'h1234, 32'h1234_0000, 17, 1'b0, "lui");
  endtask

  task automatic test_shifts();
    run_op(3'b010, 32'h8000_0010, 5'd4, 16'h0000, 32'hF800_0001, 5, 1'b0, "sra");
    run_op(3'b001, 32'h8000_0010, 5'd4, 16'h0000, 32'h0800_0001, 5, 1'b0, "srl");
    run_op(3'b000, 32'h8000_0010, 5'd4, 16'h0000, 32'h0000_0100, 5, 1'b0, "sll");
  endtask

  task automatic test_zero_cycle();
    run_op(3'b000, 32'hDEAD_BEEF, 5'd0, 16'h0000, 32'hDEAD_BEEF, 1, 1'b0, "sll0");
    run_op(3'b100, 32'h0000_0000, 5'd7, 16'h8001, 32'hFFFF_8001, 1, 1'b0, "sext");
    run_op(3'b101, 32'hFFFF_FFFF, 5'd7, 16'h8001, 32'h0000_8001, 1, 1'b0, "zext");
  endtask

  task automatic test_rotates();
    run_op(3'b111, 32'h0000_0001, 5'd1,  16'h0000, 32'h8000_0000, 2,  1'b0, "ror1");
    run_op(3'b110, 32'h8000_0000, 5'd31, 16'h0000, 32'h4000_0000, 32, 1'b0, "rol31");
  endtask

  task automatic test_back_to_back();
    run_op(3'b000, 32'h0000_0001, 5'd8, 16'h0000, 32'h0000_0100, 9, 1'b1, "ignore_busy");
    run_op(3'b001, 32'h0000_0100, 5'd8, 16'h0000, 32'h0000_0001, 9, 1'b0, "b2b_next");
  endtask

  task automatic test_abort();
    bit saw_done;
    @(negedge clk);
    mode = 3'b000; operand = 32'h0000_0001; shamt = 5'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL abort_reset: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_err++;
      $display("FAIL abort_quiet: got activity=1 want 0");
    end
    run_op(3'b001, 32'h0000_00F0, 5'd4, 16'h0000, 32'h0000_000F, 5, 1'b0, "after_abort");
  endtask

  task automatic test_rst_start_collision();
    @(negedge clk);
    mode = 3'b100; imm = 16'h8001; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || result !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL collision: got busy=%b result=%h want 0 00000000", busy, result);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL collision_quiet: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    mode = 3'b000;
    operand = 32'h0000_0000;
    shamt = 5'd0;
    imm = 16'h0000;
    test_reset();
    test_lui();
    test_shifts();
    test_zero_cycle();
    test_rotates();
    test_back_to_back();
    test_abort();
    test_rst_start_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
